// File: rtl/accelerator_dnc_pkg.sv
// Shared DNC definitions: FSM state encoding, control/data constants, fixed-point product.
// Pure declarations; no state, no latency.
package accelerator_dnc_pkg;

    localparam int DNC_DATA_SIZE     = 64;
    localparam int DNC_CONTROL_SIZE  = 64;
    localparam int DNC_FRACTION_SIZE = 32;
    localparam int DNC_MAX_W         = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD_V  = 2'd1,
        ST_LOAD_W  = 2'd2,
        ST_PRODUCT = 2'd3
    } dnc_state_t;

    localparam logic [DNC_CONTROL_SIZE-1:0] ZERO_CONTROL = '0;
    localparam logic [DNC_CONTROL_SIZE-1:0] ONE_CONTROL  = DNC_CONTROL_SIZE'(1);
    localparam logic [DNC_DATA_SIZE-1:0]    ZERO_DATA    = '0;
    localparam logic [DNC_DATA_SIZE-1:0]    ONE_DATA     = DNC_DATA_SIZE'(1);

    // Full-width signed multiply; taking DATA_SIZE bits starting at the fraction
    // position equals an arithmetic shift right followed by truncation.
    function automatic logic [DNC_DATA_SIZE-1:0] fixed_product(
        input logic [DNC_DATA_SIZE-1:0] a,
        input logic [DNC_DATA_SIZE-1:0] b,
        input int unsigned              frac
    );
        logic signed [2*DNC_DATA_SIZE-1:0] full;
        full = $signed({{DNC_DATA_SIZE{a[DNC_DATA_SIZE-1]}}, a})
             * $signed({{DNC_DATA_SIZE{b[DNC_DATA_SIZE-1]}}, b});
        return full[frac +: DNC_DATA_SIZE];
    endfunction

endpackage

// File: rtl/accelerator_vector_buffer.sv
// Write-vector storage: MAX_W x DATA_SIZE registers, synchronous write, combinational read.
// Read data is valid in the same cycle as the address; no backpressure.
module accelerator_vector_buffer #(
    parameter int DATA_SIZE = 64,
    parameter int MAX_W     = 64,
    parameter int AW        = 6
) (
    input  logic                 clk_i,
    input  logic                 wr_en_i,
    input  logic [AW-1:0]        wr_addr_i,
    input  logic [DATA_SIZE-1:0] wr_dat_i,
    input  logic [AW-1:0]        rd_addr_i,
    output logic [DATA_SIZE-1:0] rd_dat_o
);

    logic [DATA_SIZE-1:0] mem_q [MAX_W];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_dat_i;
        end
    end

    assign rd_dat_o = mem_q[rd_addr_i];

endmodule

// File: rtl/accelerator_memory_add_vector.sv
// Memory-update additive term A(j,k) = w(j)*v(k): buffer v, then one row of W products per w element.
// One product per cycle once w(j) is latched; producer stalls hold state, outputs never stall.
module accelerator_memory_add_vector
    import accelerator_dnc_pkg::*;
#(
    parameter int DATA_SIZE     = DNC_DATA_SIZE,
    parameter int CONTROL_SIZE  = DNC_CONTROL_SIZE,
    parameter int FRACTION_SIZE = DNC_FRACTION_SIZE,
    parameter int MAX_W         = DNC_MAX_W
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 READY,
    input  logic [DATA_SIZE-1:0] SIZE_N_IN,
    input  logic [DATA_SIZE-1:0] SIZE_W_IN,
    input  logic                 V_IN_ENABLE,
    input  logic [DATA_SIZE-1:0] V_IN,
    output logic                 V_IN_READY,
    input  logic                 W_IN_ENABLE,
    input  logic [DATA_SIZE-1:0] W_IN,
    output logic                 W_IN_READY,
    output logic                 M_OUT_ENABLE,
    output logic [DATA_SIZE-1:0] M_OUT
);

    localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam logic [DATA_SIZE-1:0] MAX_W_D = DATA_SIZE'(MAX_W);

    dnc_state_t state_q, state_d;

    logic [CONTROL_SIZE-1:0] size_n_q, size_n_d;
    logic [CONTROL_SIZE-1:0] size_w_q, size_w_d;
    logic [CONTROL_SIZE-1:0] j_q, j_d;
    logic [CONTROL_SIZE-1:0] k_q, k_d;
    logic [DATA_SIZE-1:0]    weight_q, weight_d;
    logic [DATA_SIZE-1:0]    m_out_q, m_out_d;
    logic                    ready_q, ready_d;
    logic                    m_vld_q, m_vld_d;
    logic                    v_rdy_q, v_rdy_d;
    logic                    w_rdy_q, w_rdy_d;

    logic                    v_acc, w_acc;
    logic                    last_k, last_j, size_empty;
    logic [DATA_SIZE-1:0]    w_clamped;
    logic [DATA_SIZE-1:0]    buf_rd_dat;

    assign v_acc      = v_rdy_q & V_IN_ENABLE;
    assign w_acc      = w_rdy_q & W_IN_ENABLE;
    assign last_k     = (k_q == size_w_q - ONE_CONTROL);
    assign last_j     = (j_q == size_n_q - ONE_CONTROL);
    assign size_empty = (SIZE_N_IN == ZERO_DATA) || (SIZE_W_IN == ZERO_DATA);
    assign w_clamped  = (SIZE_W_IN > MAX_W_D) ? MAX_W_D : SIZE_W_IN;

    accelerator_vector_buffer #(
        .DATA_SIZE (DATA_SIZE),
        .MAX_W     (MAX_W),
        .AW        (AW)
    ) u_vector_buffer (
        .clk_i     (CLK),
        .wr_en_i   (v_acc),
        .wr_addr_i (k_q[AW-1:0]),
        .wr_dat_i  (V_IN),
        .rd_addr_i (k_q[AW-1:0]),
        .rd_dat_o  (buf_rd_dat)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            size_n_q <= ZERO_CONTROL;
            size_w_q <= ZERO_CONTROL;
            j_q      <= ZERO_CONTROL;
            k_q      <= ZERO_CONTROL;
            weight_q <= '0;
            m_out_q  <= '0;
            ready_q  <= 1'b0;
            m_vld_q  <= 1'b0;
            v_rdy_q  <= 1'b0;
            w_rdy_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            size_n_q <= size_n_d;
            size_w_q <= size_w_d;
            j_q      <= j_d;
            k_q      <= k_d;
            weight_q <= weight_d;
            m_out_q  <= m_out_d;
            ready_q  <= ready_d;
            m_vld_q  <= m_vld_d;
            v_rdy_q  <= v_rdy_d;
            w_rdy_q  <= w_rdy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (START && !size_empty) state_d = ST_LOAD_V;
            ST_LOAD_V:  if (v_acc && last_k)      state_d = ST_LOAD_W;
            ST_LOAD_W:  if (w_acc)                state_d = ST_PRODUCT;
            ST_PRODUCT: if (last_k)               state_d = last_j ? ST_IDLE : ST_LOAD_W;
            default:                              state_d = ST_IDLE;
        endcase
    end

    // Ready outputs decode the next state so they are high for the whole stay in that state.
    always_comb begin
        size_n_d = size_n_q;
        size_w_d = size_w_q;
        j_d      = j_q;
        k_d      = k_q;
        weight_d = weight_q;
        m_out_d  = m_out_q;
        ready_d  = 1'b0;
        m_vld_d  = 1'b0;
        v_rdy_d  = (state_d == ST_LOAD_V);
        w_rdy_d  = (state_d == ST_LOAD_W);
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    size_n_d = CONTROL_SIZE'(SIZE_N_IN);
                    size_w_d = CONTROL_SIZE'(w_clamped);
                    j_d      = ZERO_CONTROL;
                    k_d      = ZERO_CONTROL;
                    ready_d  = size_empty;
                end
            end
            ST_LOAD_V: begin
                if (v_acc) begin
                    k_d = last_k ? ZERO_CONTROL : k_q + ONE_CONTROL;
                end
            end
            ST_LOAD_W: begin
                if (w_acc) begin
                    weight_d = W_IN;
                end
            end
            ST_PRODUCT: begin
                m_out_d = fixed_product(weight_q, buf_rd_dat, FRACTION_SIZE);
                m_vld_d = 1'b1;
                if (last_k) begin
                    k_d = ZERO_CONTROL;
                    if (last_j) begin
                        ready_d = 1'b1;
                    end else begin
                        j_d = j_q + ONE_CONTROL;
                    end
                end else begin
                    k_d = k_q + ONE_CONTROL;
                end
            end
            default: ;
        endcase
    end

    assign READY        = ready_q;
    assign M_OUT_ENABLE = m_vld_q;
    assign M_OUT        = m_out_q;
    assign V_IN_READY   = v_rdy_q;
    assign W_IN_READY   = w_rdy_q;

endmodule

// File: tb/tb_accelerator_memory_add_vector.sv
// Scoreboard bench for accelerator_memory_add_vector: directed vectors, monitor-side checking.
module tb_accelerator_memory_add_vector;

    localparam logic [63:0] FX_HALF  = 64'h0000_0000_8000_0000;
    localparam logic [63:0] FX_ONE   = 64'h0000_0001_0000_0000;
    localparam logic [63:0] FX_TWO   = 64'h0000_0002_0000_0000;
    localparam logic [63:0] FX_THREE = 64'h0000_0003_0000_0000;
    localparam logic [63:0] FX_M_HALF = 64'hFFFF_FFFF_8000_0000;
    localparam logic [63:0] FX_M_ONE = 64'hFFFF_FFFF_0000_0000;
    localparam logic [63:0] FX_M_TWO = 64'hFFFF_FFFE_0000_0000;
    localparam logic [63:0] FX_M_SIX = 64'hFFFF_FFFA_0000_0000;
    localparam int          MAXW     = 64;

    logic        CLK, RST, START, READY;
    logic [63:0] SIZE_N_IN, SIZE_W_IN;
    logic        V_IN_ENABLE, V_IN_READY, W_IN_ENABLE, W_IN_READY, M_OUT_ENABLE;
    logic [63:0] V_IN, W_IN, M_OUT;

    typedef struct {
        logic [63:0] dat;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          bare_ready_allow = 0;
    int          vrdy_seen = 0;
    logic [63:0] last_out = '0;

    accelerator_memory_add_vector dut (
        .CLK          (CLK),
        .RST          (RST),
        .START        (START),
        .READY        (READY),
        .SIZE_N_IN    (SIZE_N_IN),
        .SIZE_W_IN    (SIZE_W_IN),
        .V_IN_ENABLE  (V_IN_ENABLE),
        .V_IN         (V_IN),
        .V_IN_READY   (V_IN_READY),
        .W_IN_ENABLE  (W_IN_ENABLE),
        .W_IN         (W_IN),
        .W_IN_READY   (W_IN_READY),
        .M_OUT_ENABLE (M_OUT_ENABLE),
        .M_OUT        (M_OUT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Monitor: pops the scoreboard on every output beat, checks holds between beats.
    always @(negedge CLK) begin
        exp_t e;
        if (!RST) begin
            last_out = '0;
        end else begin
            if (V_IN_READY) vrdy_seen++;
            if (M_OUT_ENABLE) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_output M_OUT=%h (no output expected)", M_OUT);
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if (M_OUT !== e.dat) begin
                        errors++;
                        $display("FAIL m_out got %h expected %h", M_OUT, e.dat);
                    end
                    checks++;
                    if (READY !== e.last) begin
                        errors++;
                        $display("FAIL ready_with_last got %b expected %b", READY, e.last);
                    end
                end
                last_out = M_OUT;
            end else begin
                checks++;
                if (M_OUT !== last_out) begin
                    errors++;
                    $display("FAIL m_out_hold got %h expected %h", M_OUT, last_out);
                end
                if (READY) begin
                    checks++;
                    if (bare_ready_allow == 0) begin
                        errors++;
                        $display("FAIL ready_without_output got 1 expected 0");
                    end else begin
                        bare_ready_allow--;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_out(input logic [63:0] d, input logic last);
        exp_t e;
        e.dat = d;
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic start_op(input logic [63:0] n, input logic [63:0] w);
        @(negedge CLK);
        SIZE_N_IN = n;
        SIZE_W_IN = w;
        START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
    endtask

    task automatic push_v(input logic [63:0] d, input int gap);
        int n;
        repeat (gap) @(negedge CLK);
        @(negedge CLK);
        V_IN_ENABLE = 1'b1;
        V_IN = d;
        n = 0;
        while (!V_IN_READY && n < 300) begin
            @(negedge CLK);
            n++;
        end
        if (!V_IN_READY) begin
            checks++; errors++;
            $display("FAIL v_handshake_timeout got V_IN_READY=0 expected 1");
        end
        @(posedge CLK);
        #1 V_IN_ENABLE = 1'b0;
    endtask

    task automatic push_w(input logic [63:0] d, input int gap);
        int n;
        repeat (gap) @(negedge CLK);
        @(negedge CLK);
        W_IN_ENABLE = 1'b1;
        W_IN = d;
        n = 0;
        while (!W_IN_READY && n < 300) begin
            @(negedge CLK);
            n++;
        end
        if (!W_IN_READY) begin
            checks++; errors++;
            $display("FAIL w_handshake_timeout got W_IN_READY=0 expected 1");
        end
        @(posedge CLK);
        #1 W_IN_ENABLE = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        chk("drain_remaining", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge CLK);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ready"}, {63'd0, READY}, 64'd0);
        chk({tag, "_m_out_enable"}, {63'd0, M_OUT_ENABLE}, 64'd0);
        chk({tag, "_v_in_ready"}, {63'd0, V_IN_READY}, 64'd0);
        chk({tag, "_w_in_ready"}, {63'd0, W_IN_READY}, 64'd0);
        chk({tag, "_m_out"}, M_OUT, 64'd0);
    endtask

    task automatic basic_2x3(input int gap);
        logic [63:0] v[3];
        v[0] = FX_ONE; v[1] = FX_TWO; v[2] = FX_M_ONE;
        expect_out(FX_HALF, 1'b0);
        expect_out(FX_ONE, 1'b0);
        expect_out(FX_M_HALF, 1'b0);
        expect_out(FX_ONE, 1'b0);
        expect_out(FX_TWO, 1'b0);
        expect_out(FX_M_ONE, 1'b1);
        start_op(64'd2, 64'd3);
        for (int k = 0; k < 3; k++) push_v(v[k], gap);
        push_w(FX_HALF, gap);
        push_w(FX_ONE, gap);
        wait_drain(200);
    endtask

    initial begin
        int n;
        RST = 1'b0;
        START = 1'b0;
        SIZE_N_IN = '0;
        SIZE_W_IN = '0;
        V_IN_ENABLE = 1'b0;
        V_IN = '0;
        W_IN_ENABLE = 1'b0;
        W_IN = '0;
        repeat (3) @(negedge CLK);
        check_idle_outputs("reset");
        RST = 1'b1;

        // Basic 2x3, then the same data with 1-0-1 stalls on both producers.
        basic_2x3(0);
        basic_2x3(1);

        // Zero size: bare READY one cycle after START, loading never entered.
        vrdy_seen = 0;
        bare_ready_allow = 1;
        start_op(64'd0, 64'd4);
        @(negedge CLK);
        chk("zero_size_ready", {63'd0, READY}, 64'd1);
        repeat (4) @(negedge CLK);
        chk("zero_size_ready_consumed", 64'(bare_ready_allow), 64'd0);
        chk("zero_size_v_in_ready_seen", 64'(vrdy_seen), 64'd0);

        // Clamp: W=MAX_W+5 with spurious W_IN_ENABLE during LOAD_V and START during PRODUCT.
        for (int j = 0; j < 2; j++)
            for (int k = 0; k < MAXW; k++)
                expect_out(64'(k * (j + 1)) << 32, (j == 1) && (k == MAXW - 1));
        start_op(64'd2, 64'(MAXW + 5));
        W_IN_ENABLE = 1'b1;
        W_IN = 64'hDEAD_BEEF_0000_0000;
        for (int k = 0; k < MAXW; k++) push_v(64'(k) << 32, 0);
        W_IN_ENABLE = 1'b0;
        push_w(FX_ONE, 0);
        @(negedge CLK);
        SIZE_N_IN = 64'd1;
        SIZE_W_IN = 64'd1;
        START = 1'b1;
        repeat (3) @(negedge CLK);
        START = 1'b0;
        push_w(FX_TWO, 0);
        wait_drain(400);

        // Reset during PRODUCT at k=1.
        expect_out(FX_ONE, 1'b0);
        start_op(64'd1, 64'd4);
        push_v(FX_ONE, 0);
        push_v(FX_TWO, 0);
        push_v(FX_THREE, 0);
        push_v(FX_M_ONE, 0);
        push_w(FX_ONE, 0);
        n = 0;
        while (!M_OUT_ENABLE && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("reset_test_first_output", {63'd0, M_OUT_ENABLE}, 64'd1);
        #2 RST = 1'b0;
        #1 check_idle_outputs("async_reset");
        exp_q.delete();
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check_idle_outputs("post_reset");

        expect_out(FX_M_SIX, 1'b1);
        start_op(64'd1, 64'd1);
        push_v(FX_THREE, 0);
        push_w(FX_M_TWO, 0);
        wait_drain(50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
